// File: rtl/elevator_pkg.sv
// Shared types and helpers for the multi-car elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR, HALT} car_state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    localparam int DEF_MOVE_CYCLES = 2;
    localparam int DEF_DOOR_CYCLES = 3;

    function automatic int floor_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_car.sv
// One car: scheduling FSM, floor register, move/door timers and the
// call-clear masks it raises during the first door cycle.
module elevator_car
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = 7,
    parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
    parameter int FLOOR_W     = floor_w(N_FLOORS)
) (
    input  logic                clock,
    input  logic                reset_start,
    input  logic                emergency,
    input  logic [N_FLOORS-1:0] car_pend,
    input  logic [N_FLOORS-1:0] hall_up_pend,
    input  logic [N_FLOORS-1:0] hall_dn_pend,
    output logic [FLOOR_W-1:0]  floor,
    output logic [1:0]          dir,
    output logic                door_open,
    output car_state_t          state,
    output logic [N_FLOORS-1:0] clr_car,
    output logic [N_FLOORS-1:0] clr_up,
    output logic [N_FLOORS-1:0] clr_dn
);
    localparam int MC_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DC_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    logic [MC_W-1:0]     move_cnt;
    logic [DC_W-1:0]     door_cnt;
    logic [1:0]          last_dir;
    logic                door_all;
    logic [N_FLOORS-1:0] demand;
    logic [N_FLOORS-1:0] oh;
    logic [FLOOR_W-1:0]  nf;
    logic                here, above, below, going_up, stop, ahead_cur, sweep;

    function automatic logic at(input logic [N_FLOORS-1:0] d, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) == f) r = d[i];
        return r;
    endfunction

    function automatic logic beyond(input logic [N_FLOORS-1:0] d, input logic [FLOOR_W-1:0] f,
                                    input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (up ? (FLOOR_W'(i) > f) : (FLOOR_W'(i) < f)) r = r | d[i];
        return r;
    endfunction

    always_comb begin
        demand    = car_pend | hall_up_pend | hall_dn_pend;
        here      = at(demand, floor);
        above     = beyond(demand, floor, 1'b1);
        below     = beyond(demand, floor, 1'b0);
        going_up  = (last_dir == DIR_UP);
        nf        = going_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
        // Stop at the next floor for our own call, a same-direction hall call, or end of run.
        stop      = at(car_pend, nf) | (going_up ? at(hall_up_pend, nf) : at(hall_dn_pend, nf))
                  | ~beyond(demand, nf, going_up);
        ahead_cur = (last_dir == DIR_UP) ? above : (last_dir == DIR_DN) ? below : 1'b0;
        // A stop made from IDLE, or with nothing further ahead, serves both hall buttons.
        sweep     = door_all | ~ahead_cur;
        oh        = N_FLOORS'(1) << floor;
        clr_car   = '0;
        clr_up    = '0;
        clr_dn    = '0;
        if (state == DOOR && door_cnt == '0) begin
            clr_car = oh;
            if (sweep || last_dir == DIR_UP) clr_up = oh;
            if (sweep || last_dir == DIR_DN) clr_dn = oh;
        end
        door_open = (state == DOOR);
        dir       = (state == MOVE || state == DOOR) ? last_dir : DIR_IDLE;
    end

    always_ff @(posedge clock or negedge reset_start) begin
        if (!reset_start) begin
            state    <= IDLE;
            floor    <= '0;
            last_dir <= DIR_IDLE;
            move_cnt <= '0;
            door_cnt <= '0;
            door_all <= 1'b0;
        end else if (emergency) begin
            state <= HALT;
        end else begin
            case (state)
                HALT: begin
                    state    <= IDLE;
                    move_cnt <= '0;
                    door_cnt <= '0;
                end
                IDLE: begin
                    if (here) begin
                        state    <= DOOR;
                        door_all <= 1'b1;
                    end else if (above && (last_dir != DIR_DN || !below)) begin
                        state    <= MOVE;
                        last_dir <= DIR_UP;
                    end else if (below) begin
                        state    <= MOVE;
                        last_dir <= DIR_DN;
                    end
                end
                MOVE: begin
                    if (move_cnt == MC_W'(MOVE_CYCLES - 1)) begin
                        move_cnt <= '0;
                        floor    <= nf;
                        if (stop) begin
                            state    <= DOOR;
                            door_all <= 1'b0;
                        end
                    end else begin
                        move_cnt <= move_cnt + MC_W'(1);
                    end
                end
                DOOR: begin
                    if (door_cnt == DC_W'(DOOR_CYCLES - 1)) begin
                        door_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        door_cnt <= door_cnt + DC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-car elevator controller: hall/car call registers, per-car FSM array,
// merged call clearing, busy-time counter and idle flag.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int  N_FLOORS    = 7,
    parameter int  N_CARS      = 2,
    parameter int  MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int  DOOR_CYCLES = DEF_DOOR_CYCLES,
    parameter int  TIME_W      = 8,
    localparam int FLOOR_W     = floor_w(N_FLOORS)
) (
    input  logic                        clock,
    input  logic                        reset_start,
    input  logic [N_FLOORS-1:0]         hall_up_req,
    input  logic [N_FLOORS-1:0]         hall_dn_req,
    input  logic [N_CARS*N_FLOORS-1:0]  car_req,
    input  logic [N_CARS-1:0]           emergency,
    output logic [N_CARS*FLOOR_W-1:0]   car_floor,
    output logic [N_CARS*2-1:0]         car_dir,
    output logic [N_CARS-1:0]           door_open,
    output logic [N_FLOORS-1:0]         hall_up_pend,
    output logic [N_FLOORS-1:0]         hall_dn_pend,
    output logic [N_CARS*N_FLOORS-1:0]  car_pend,
    output logic [TIME_W-1:0]           time_counter,
    output logic                        all_idle
);
    localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    logic [N_CARS-1:0][N_FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic [N_FLOORS-1:0]             up_clr, dn_clr;
    car_state_t                      st [N_CARS];

    for (genvar g = 0; g < N_CARS; g++) begin : g_car
        elevator_car #(
            .N_FLOORS   (N_FLOORS),
            .MOVE_CYCLES(MOVE_CYCLES),
            .DOOR_CYCLES(DOOR_CYCLES),
            .FLOOR_W    (FLOOR_W)
        ) u_car (
            .clock       (clock),
            .reset_start (reset_start),
            .emergency   (emergency[g]),
            .car_pend    (car_pend[g*N_FLOORS +: N_FLOORS]),
            .hall_up_pend(hall_up_pend),
            .hall_dn_pend(hall_dn_pend),
            .floor       (car_floor[g*FLOOR_W +: FLOOR_W]),
            .dir         (car_dir[g*2 +: 2]),
            .door_open   (door_open[g]),
            .state       (st[g]),
            .clr_car     (clr_car[g]),
            .clr_up      (clr_up[g]),
            .clr_dn      (clr_dn[g])
        );
    end

    // Several cars may clear the same hall bit at once; the lowest index is the
    // credited one, but the register only needs the union.
    always_comb begin
        up_clr   = '0;
        dn_clr   = '0;
        all_idle = ~(|hall_up_pend | |hall_dn_pend | |car_pend);
        for (int k = 0; k < N_CARS; k++) begin
            up_clr = up_clr | clr_up[k];
            dn_clr = dn_clr | clr_dn[k];
            if (st[k] != IDLE) all_idle = 1'b0;
        end
    end

    // Set wins over clear on the same edge.
    always_ff @(posedge clock or negedge reset_start) begin
        if (!reset_start) begin
            hall_up_pend <= '0;
            hall_dn_pend <= '0;
            car_pend     <= '0;
            time_counter <= '0;
        end else begin
            hall_up_pend <= (hall_up_pend & ~up_clr) | (hall_up_req & UP_MASK);
            hall_dn_pend <= (hall_dn_pend & ~dn_clr) | (hall_dn_req & DN_MASK);
            car_pend     <= (car_pend & ~clr_car) | car_req;
            if (!all_idle && time_counter != '1)
                time_counter <= time_counter + TIME_W'(1);
        end
    end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n: per-cycle behavioural model plus literal checkpoints.
module tb_elevator_ctrl_n;
    localparam int NF = 7;
    localparam int NC = 2;
    localparam int MC = 2;
    localparam int DC = 3;
    localparam int TW = 4;
    localparam int FW = 3;
    localparam int S_IDLE = 0, S_MOVE = 1, S_DOOR = 2, S_HALT = 3;

    logic                clock = 1'b0;
    logic                reset_start = 1'b0;
    logic [NF-1:0]       hall_up_req = '0;
    logic [NF-1:0]       hall_dn_req = '0;
    logic [NC*NF-1:0]    car_req = '0;
    logic [NC-1:0]       emergency = '0;
    logic [NC*FW-1:0]    car_floor;
    logic [NC*2-1:0]     car_dir;
    logic [NC-1:0]       door_open;
    logic [NF-1:0]       hall_up_pend, hall_dn_pend;
    logic [NC*NF-1:0]    car_pend;
    logic [TW-1:0]       time_counter;
    logic                all_idle;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    elevator_ctrl_n #(.N_FLOORS(NF), .N_CARS(NC), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC), .TIME_W(TW)) dut (
        .clock(clock), .reset_start(reset_start), .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req),
        .car_req(car_req), .emergency(emergency), .car_floor(car_floor), .car_dir(car_dir),
        .door_open(door_open), .hall_up_pend(hall_up_pend), .hall_dn_pend(hall_dn_pend),
        .car_pend(car_pend), .time_counter(time_counter), .all_idle(all_idle));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_fl[NC], m_st[NC], m_ld[NC], m_tl[NC];
    bit m_all[NC];
    bit m_hu[NF], m_hd[NF];
    bit m_cc[NC][NF];
    int m_tc;

    function automatic bit dem(int k, int f);
        return m_cc[k][f] | m_hu[f] | m_hd[f];
    endfunction

    // d: 1 = look above f, 2 = look below f, otherwise nothing ahead
    function automatic bit ahead(int k, int f, int d);
        for (int i = 0; i < NF; i++)
            if (((d == 1 && i > f) || (d == 2 && i < f)) && dem(k, i)) return 1;
        return 0;
    endfunction

    function automatic bit m_idle();
        for (int f = 0; f < NF; f++) begin
            if (m_hu[f] || m_hd[f]) return 0;
            for (int k = 0; k < NC; k++) if (m_cc[k][f]) return 0;
        end
        for (int k = 0; k < NC; k++) if (m_st[k] != S_IDLE) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_fl[k] = 0; m_st[k] = S_IDLE; m_ld[k] = 0; m_tl[k] = 0; m_all[k] = 0;
            for (int f = 0; f < NF; f++) m_cc[k][f] = 0;
        end
        for (int f = 0; f < NF; f++) begin m_hu[f] = 0; m_hd[f] = 0; end
        m_tc = 0;
    endtask

    task automatic model_step();
        bit cu[NF];
        bit cd[NF];
        bit cc[NC][NF];
        bit busy, sweep, stop;
        int f, nf;
        busy = !m_idle();
        for (int i = 0; i < NF; i++) begin
            cu[i] = 0; cd[i] = 0;
            for (int k = 0; k < NC; k++) cc[k][i] = 0;
        end
        for (int k = 0; k < NC; k++)
            if (m_st[k] == S_DOOR && m_tl[k] == DC) begin
                f = m_fl[k];
                cc[k][f] = 1;
                sweep = m_all[k] || !ahead(k, f, m_ld[k]);
                if (sweep || m_ld[k] == 1) cu[f] = 1;
                if (sweep || m_ld[k] == 2) cd[f] = 1;
            end
        for (int k = 0; k < NC; k++) begin
            f = m_fl[k];
            if (emergency[k]) m_st[k] = S_HALT;
            else case (m_st[k])
                S_HALT: m_st[k] = S_IDLE;
                S_IDLE:
                    if (dem(k, f)) begin
                        m_st[k] = S_DOOR; m_tl[k] = DC; m_all[k] = 1;
                    end else if (ahead(k, f, 1) && (m_ld[k] != 2 || !ahead(k, f, 2))) begin
                        m_st[k] = S_MOVE; m_ld[k] = 1; m_tl[k] = MC;
                    end else if (ahead(k, f, 2)) begin
                        m_st[k] = S_MOVE; m_ld[k] = 2; m_tl[k] = MC;
                    end
                S_MOVE:
                    if (m_tl[k] > 1) m_tl[k]--;
                    else begin
                        nf = f + ((m_ld[k] == 1) ? 1 : -1);
                        m_fl[k] = nf;
                        stop = m_cc[k][nf] || (m_ld[k] == 1 ? m_hu[nf] : m_hd[nf]) || !ahead(k, nf, m_ld[k]);
                        if (stop) begin m_st[k] = S_DOOR; m_tl[k] = DC; m_all[k] = 0; end
                        else m_tl[k] = MC;
                    end
                default:
                    if (m_tl[k] > 1) m_tl[k]--;
                    else m_st[k] = S_IDLE;
            endcase
        end
        for (int i = 0; i < NF; i++) begin
            m_hu[i] = (m_hu[i] && !cu[i]) || (hall_up_req[i] && i != NF-1);
            m_hd[i] = (m_hd[i] && !cd[i]) || (hall_dn_req[i] && i != 0);
            for (int k = 0; k < NC; k++)
                m_cc[k][i] = (m_cc[k][i] && !cc[k][i]) || car_req[k*NF+i];
        end
        if (busy && m_tc < (1 << TW) - 1) m_tc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_start);
            if (!reset_start) model_reset();
            else model_step();
        end
    end

    task automatic compare_all();
        logic [NC*FW-1:0] ef;
        logic [NC*2-1:0]  ed;
        logic [NC-1:0]    eo;
        logic [NF-1:0]    eu, en;
        logic [NC*NF-1:0] ec;
        for (int k = 0; k < NC; k++) begin
            ef[k*FW +: FW] = FW'(m_fl[k]);
            ed[k*2 +: 2]   = (m_st[k] == S_MOVE || m_st[k] == S_DOOR) ? 2'(m_ld[k]) : 2'b00;
            eo[k]          = (m_st[k] == S_DOOR);
            for (int f = 0; f < NF; f++) ec[k*NF+f] = m_cc[k][f];
        end
        for (int f = 0; f < NF; f++) begin eu[f] = m_hu[f]; en[f] = m_hd[f]; end
        check("model car_floor", 32'(car_floor), 32'(ef));
        check("model car_dir", 32'(car_dir), 32'(ed));
        check("model door_open", 32'(door_open), 32'(eo));
        check("model hall_up_pend", 32'(hall_up_pend), 32'(eu));
        check("model hall_dn_pend", 32'(hall_dn_pend), 32'(en));
        check("model car_pend", 32'(car_pend), 32'(ec));
        check("model time_counter", 32'(time_counter), 32'(m_tc));
        check("model all_idle", 32'(all_idle), 32'(m_idle()));
    endtask

    initial forever begin
        @(negedge clock);
        if (chk_en && reset_start) compare_all();
    end

    // ---------------- stimulus ----------------
    task automatic go(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset_start = 1'b0;
        go(2);
        #2 reset_start = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " floor"}, 32'(car_floor), 0);
        check({tag, " dir"}, 32'(car_dir), 0);
        check({tag, " door"}, 32'(door_open), 0);
        check({tag, " pend"}, 32'(car_pend) | 32'(hall_up_pend) | 32'(hall_dn_pend), 0);
        check({tag, " time"}, 32'(time_counter), 0);
        check({tag, " all_idle"}, 32'(all_idle), 1);
    endtask

    initial begin
        go(1);
        check_reset_state("reset");
        do_reset();
        chk_en = 1;

        // single ride: car0 to floor 3, then back to 0 to saturate the busy counter
        @(negedge clock); car_req[3] = 1'b1; go(1); car_req = '0;
        check("ride pend set", 32'(car_pend), 32'h8);
        go(1); check("ride dir up", 32'(car_dir[1:0]), 1);
        go(2); check("ride floor1 e3", 32'(car_floor[2:0]), 1);
        go(4); check("ride floor3 e7", 32'(car_floor[2:0]), 3);
        check("ride door e7", 32'(door_open), 1);
        go(1); check("ride pend clr e8", 32'(car_pend), 0);
        go(2); check("ride door shut e10", 32'(door_open), 0);
        check("ride time e10", 32'(time_counter), 10);
        check("ride all_idle e10", 32'(all_idle), 1);
        car_req[0] = 1'b1; go(1); car_req = '0;
        go(10);
        check("sat floor0", 32'(car_floor[2:0]), 0);
        check("sat time 15", 32'(time_counter), 15);

        // boundary masking
        do_reset();
        @(negedge clock); hall_up_req[6] = 1'b1; hall_dn_req[0] = 1'b1; go(1);
        hall_up_req = '0; hall_dn_req = '0;
        check("mask up6", 32'(hall_up_pend), 0);
        check("mask dn0", 32'(hall_dn_pend), 0);
        go(3);
        check("mask all_idle", 32'(all_idle), 1);
        check("mask time", 32'(time_counter), 0);

        // direction service, car1 parked in emergency
        emergency = 2'b10;
        do_reset();
        @(negedge clock);
        car_req[5] = 1'b1; hall_up_req[2] = 1'b1; hall_dn_req[4] = 1'b1;
        go(1); car_req = '0; hall_up_req = '0; hall_dn_req = '0;
        go(5); check("dir stop2", 32'(car_floor[2:0]), 2);
        check("dir door2", 32'(door_open[0]), 1);
        go(1); check("dir hu2 clr", 32'(hall_up_pend), 0);
        check("dir hd4 kept", 32'(hall_dn_pend), 32'h10);
        go(7); check("dir pass4 floor", 32'(car_floor[2:0]), 4);
        check("dir pass4 door", 32'(door_open[0]), 0);
        go(2); check("dir stop5 door", 32'(door_open[0]), 1);
        go(6); check("dir back4 floor", 32'(car_floor[2:0]), 4);
        check("dir back4 dir", 32'(car_dir[1:0]), 2);
        go(3); check("dir hd4 clr", 32'(hall_dn_pend), 0);
        check("dir car1 halt", 32'(car_dir[3:2]), 0);
        emergency = '0;
        go(4);

        // emergency mid-move on car1
        do_reset();
        @(negedge clock); car_req[NF+4] = 1'b1; go(1); car_req = '0;
        go(4); emergency[1] = 1'b1;
        go(3); check("emg frozen floor", 32'(car_floor[5:3]), 1);
        check("emg dir", 32'(car_dir[3:2]), 0);
        check("emg door", 32'(door_open[1]), 0);
        go(2); emergency[1] = 1'b0;
        go(8); check("emg arrive floor", 32'(car_floor[5:3]), 4);
        check("emg arrive door", 32'(door_open[1]), 1);
        go(4);

        // simultaneous arrival at floor 2, hall re-pulse on the clear edge
        do_reset();
        @(negedge clock); car_req[2] = 1'b1; car_req[NF+2] = 1'b1; hall_up_req[2] = 1'b1;
        go(1); car_req = '0; hall_up_req = '0;
        go(5); check("sim both doors", 32'(door_open), 3);
        check("sim both floor2", 32'(car_floor), 32'h12);
        hall_up_req[2] = 1'b1; go(1); hall_up_req = '0;
        check("sim set wins", 32'(hall_up_pend), 32'h4);
        check("sim car calls clr", 32'(car_pend), 0);
        go(4); check("sim reopen clr", 32'(hall_up_pend), 0);
        check("sim reopen doors", 32'(door_open), 3);
        go(4);

        // asynchronous reset mid-move
        @(negedge clock); car_req[6] = 1'b1; go(1); car_req = '0;
        go(4);
        #2 reset_start = 1'b0;
        #1 check_reset_state("midmove reset");
        go(2);
        #2 reset_start = 1'b1;
        go(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
Parametrised next-generation elevator controller for N_CARS cars serving N_FLOORS floors.
- Registers hall calls (up/down per floor) and car calls (per car, per floor).
- Runs one independent scheduling FSM per car, with movement timing, door dwell and per-car emergency halt.
- Sits under the elevator top level. Replaces the fixed 7-floor/2-car datapath with a generic call-register and car-FSM structure, plus a saturating busy-time counter.

Parameters:
N_FLOORS, 7, number of floors (min 2); floor index 0..N_FLOORS-1
N_CARS, 2, number of cars (min 1)
MOVE_CYCLES, 2, clock cycles per one-floor move (min 1)
DOOR_CYCLES, 3, cycles door stays open per stop (min 1)
TIME_W, 8, width of busy-time counter

Ports:
clock  in  1  system clock, rising edge
reset_start  in  1  asynchronous, active-low reset
hall_up_req  in  N_FLOORS  one-cycle pulses, up call per floor; bit N_FLOORS-1 ignored
hall_dn_req  in  N_FLOORS  down call per floor; bit 0 ignored
car_req  in  N_CARS*N_FLOORS  car call pulses, car k at [k*N_FLOORS +: N_FLOORS]
emergency  in  N_CARS  level, halts car k while high
car_floor  out  N_CARS*FLOOR_W  current floor per car, FLOOR_W=clog2(N_FLOORS)
car_dir  out  N_CARS*2  per car: 00 idle, 01 up, 10 down
door_open  out  N_CARS  high while car in DOOR
hall_up_pend, hall_dn_pend  out  N_FLOORS  registered hall calls
car_pend  out  N_CARS*N_FLOORS  registered car calls
time_counter  out  TIME_W  busy cycles, saturating
all_idle  out  1  no call pending and every car IDLE

Behaviour:
- Reset (reset_start low, async): all call registers 0; every car at floor 0, state IDLE, dir 00, door 0, counters 0; time_counter 0; all_idle 1.
- Call registers:
  - A request pulse sets its bit on the next edge.
  - Set and clear of the same bit on the same edge: set wins.
  - Masked bits (up at top floor, down at floor 0) are never set.
- Per-car FSM states: IDLE, MOVE, DOOR, HALT.
  - A car's demand is its own car calls plus all hall calls.
- IDLE:
  - Demand at the current floor -> DOOR.
  - Else demand above and last direction up (or no demand below) -> MOVE, dir up.
  - Else demand below -> MOVE, dir down.
  - Else stay, dir 00.
  - Tie with no history: up.
- MOVE:
  - Move counter counts 0..MOVE_CYCLES-1. On the wrap edge, floor steps by ±1.
  - On that same edge, if the new floor has a car call, or a hall call in the travel direction, or no demand beyond it -> DOOR; else stay in MOVE.
  - Floor never leaves 0..N_FLOORS-1; the FSM reverses via IDLE instead.
- DOOR:
  - On entry, clear the car's own car call at that floor and the hall call matching dir.
  - If no demand remains beyond the floor in dir, clear both hall calls at that floor.
  - Dwell DOOR_CYCLES cycles, then -> IDLE. Last direction is retained for the IDLE decision.
- HALT:
  - emergency[k] high forces HALT on the next edge from any state.
  - Floor and move counter are frozen; door_open 0; dir 00.
  - Calls still register.
  - On deassert -> IDLE, with the move counter reset.
- Multiple cars:
  - Cars reaching the same floor on the same edge may both open.
  - A hall call is cleared once; the lowest-index car is credited.
  - No cross-car assignment otherwise.
- time_counter increments each cycle where all_idle is 0. It holds at 2^TIME_W-1.
- Request pulses during reset are lost.

Decomposition:
- Shared package elevator_pkg holds:
  - car state enum (IDLE, MOVE, DOOR, HALT);
  - direction encoding (DIR_IDLE, DIR_UP, DIR_DN);
  - FLOOR_W function;
  - defaults for MOVE_CYCLES and DOOR_CYCLES.
- Sub-module elevator_car:
  - One per car via generate.
  - Contains the FSM, floor register, move/door counters and demand-above/below reduction.
  - Emits per-car clear masks.
- Top level handles:
  - call registers;
  - lowest-index clear merge;
  - time_counter;
  - all_idle.

Test Plan:
- Single ride: car 0 at floor 0, car_req car0 floor 3 at edge 0 -> MOVE at edge 1; floor 1/2/3 at edges 3/5/7; door_open rises edge 7 for 3 cycles; car_pend bit clears.
- Direction service: car 0 going up with car call 5, hall_up at 2 and hall_dn at 4 -> stops at 2, passes 4, stops at 5, then returns to 4.
- Boundary masking: hall_up_req[6] and hall_dn_req[0] pulsed -> pend bits stay 0, all_idle stays 1, time_counter stays 0.
- Emergency mid-move: car 1 moving up, emergency[1] high for 5 cycles -> floor frozen, door 0, dir 00; on release resumes and reaches target.
- Simultaneous arrival and conflict: both cars stop at floor 2 on the same edge with hall_up[2] pending -> both doors open, bit cleared once. Re-pulse on the clear edge -> bit remains set.
- Saturation and reset: TIME_W=4, busy 20 cycles -> time_counter holds 15; reset_start low mid-MOVE -> immediate all-zero outputs, floor 0.
